// File: rtl/reg_step_pkg.sv
// Shared types and constants for the register/PC step sequencer.
package reg_step_pkg;

    typedef enum logic [1:0] {
        OP_INCR = 2'b00,
        OP_DECR = 2'b01,
        OP_JIZR = 2'b10,
        OP_JNZR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_WB   = 2'b10
    } state_e;

    localparam int BR_DEFAULT = 16;

    function automatic logic is_jump(input op_e op);
        return op[1];
    endfunction

endpackage

// File: rtl/step_regfile.sv
// NREG x DW register file: one synchronous write port, two combinational read ports.
module step_regfile #(
    parameter int NREG = 8,
    parameter int DW   = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    we,
    input  logic [$clog2(NREG)-1:0] waddr,
    input  logic [DW-1:0]           wdata,
    input  logic [$clog2(NREG)-1:0] raddr_a,
    output logic [DW-1:0]           rdata_a,
    input  logic [$clog2(NREG)-1:0] raddr_b,
    output logic [DW-1:0]           rdata_b
);

    logic [DW-1:0] regs_q [NREG];
    logic [DW-1:0] regs_d [NREG];

    always_comb begin
        regs_d = regs_q;
        if (we) begin
            regs_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rdata_a = regs_q[raddr_a];
    assign rdata_b = regs_q[raddr_b];

endmodule

// File: rtl/reg_step_ctrl.sv
// Register/PC sequencer: issues one incr/decr/jizr/jnzr op to the external
// arithmetic stage and writes its result back to the register file or the PC.
module reg_step_ctrl
    import reg_step_pkg::*;
#(
    parameter int NREG = 8,
    parameter int DW   = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    op_valid,
    output logic                    op_ready,
    input  logic [1:0]              op_code,
    input  logic [$clog2(NREG)-1:0] op_reg,
    input  logic [2:0]              op_imm,
    output logic [DW-1:0]           arith_x,
    output logic [2:0]              arith_v,
    output logic                    arith_incr,
    output logic                    arith_decr,
    output logic                    arith_jizr,
    output logic                    arith_jnzr,
    input  logic [DW-1:0]           arith_res,
    output logic [DW-1:0]           pc,
    input  logic [$clog2(NREG)-1:0] rd_addr,
    output logic [DW-1:0]           rd_data,
    output logic                    done,
    output logic                    taken
);

    localparam int AW = $clog2(NREG);

    state_e          state_q,  state_d;
    op_e             op_q,     op_d;
    logic [AW-1:0]   reg_q,    reg_d;
    logic [2:0]      imm_q,    imm_d;
    logic [DW-1:0]   x_q,      x_d;
    logic [DW-1:0]   res_q,    res_d;
    logic [DW-1:0]   pc_q,     pc_d;
    logic [3:0]      strobe_q, strobe_d;
    logic            done_q,   done_d;
    logic            taken_q,  taken_d;

    logic [AW-1:0]   opnd_addr;
    logic [DW-1:0]   opnd_data;
    logic [DW-1:0]   pc_inc;
    logic            rf_we;

    // Operand port follows the incoming op while idle, the latched op afterwards.
    assign opnd_addr = (state_q == S_IDLE) ? op_reg : reg_q;
    assign pc_inc    = pc_q + {{(DW-1){1'b0}}, 1'b1};
    assign rf_we     = (state_q == S_WB) && !is_jump(op_q);

    step_regfile #(
        .NREG (NREG),
        .DW   (DW)
    ) u_regfile (
        .clk     (clk),
        .reset   (reset),
        .we      (rf_we),
        .waddr   (reg_q),
        .wdata   (res_q),
        .raddr_a (opnd_addr),
        .rdata_a (opnd_data),
        .raddr_b (rd_addr),
        .rdata_b (rd_data)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        reg_d    = reg_q;
        imm_d    = imm_q;
        x_d      = x_q;
        res_d    = res_q;
        pc_d     = pc_q;
        strobe_d = strobe_q;
        done_d   = done_q;
        taken_d  = taken_q;
        unique case (state_q)
            S_IDLE: begin
                if (op_valid) begin
                    op_d     = op_e'(op_code);
                    reg_d    = op_reg;
                    imm_d    = op_imm;
                    x_d      = op_code[1] ? pc_q : opnd_data;
                    strobe_d = 4'b0001 << op_code;
                    state_d  = S_EXEC;
                end
            end
            S_EXEC: begin
                res_d    = arith_res;
                strobe_d = 4'b0000;
                done_d   = 1'b1;
                state_d  = S_WB;
                unique case (op_q)
                    OP_JIZR: taken_d = (opnd_data == '0);
                    OP_JNZR: taken_d = (opnd_data != '0);
                    default: taken_d = 1'b0;
                endcase
            end
            S_WB: begin
                // A not-taken jump advances through the local incrementer, not arith_res.
                pc_d    = (is_jump(op_q) && taken_q) ? res_q : pc_inc;
                done_d  = 1'b0;
                taken_d = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= OP_INCR;
            reg_q    <= '0;
            imm_q    <= '0;
            x_q      <= '0;
            res_q    <= '0;
            pc_q     <= '0;
            strobe_q <= '0;
            done_q   <= 1'b0;
            taken_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            reg_q    <= reg_d;
            imm_q    <= imm_d;
            x_q      <= x_d;
            res_q    <= res_d;
            pc_q     <= pc_d;
            strobe_q <= strobe_d;
            done_q   <= done_d;
            taken_q  <= taken_d;
        end
    end

    assign op_ready   = (state_q == S_IDLE);
    assign arith_x    = x_q;
    assign arith_v    = imm_q;
    assign arith_incr = strobe_q[0];
    assign arith_decr = strobe_q[1];
    assign arith_jizr = strobe_q[2];
    assign arith_jnzr = strobe_q[3];
    assign pc         = pc_q;
    assign done       = done_q;
    assign taken      = taken_q;

endmodule

// File: tb/tb_reg_step_ctrl.sv
// Directed bench for reg_step_ctrl with an arithmetic-stage stub and an
// op-level model that is compared against the DUT every cycle.
module tb_reg_step_ctrl;

   logic       clk;
   logic       reset;
   logic       opValid;
   logic       opReady;
   logic [1:0] opCode;
   logic [2:0] opReg;
   logic [2:0] opImm;
   logic [7:0] arithX;
   logic [2:0] arithV;
   logic       arithIncr;
   logic       arithDecr;
   logic       arithJizr;
   logic       arithJnzr;
   logic [7:0] arithRes;
   logic [7:0] pcOut;
   logic [2:0] rdAddr;
   logic [7:0] rdData;
   logic       doneOut;
   logic       takenOut;

   int nVec = 0;
   int nMis = 0;
   logic checkEn = 1'b0;

   // Op-level model state: phase 0 idle, 1 exec, 2 writeback
   int         mPhase = 0;
   logic [1:0] mOp = 2'd0;
   logic [2:0] mReg = 3'd0;
   logic [2:0] mImm = 3'd0;
   logic [7:0] mRegs [8] = '{default: 8'd0};
   logic [7:0] mPc = 8'd0;
   logic       mTaken = 1'b0;

   logic       wbDone;
   logic       wbTaken;

   reg_step_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .op_valid   (opValid),
      .op_ready   (opReady),
      .op_code    (opCode),
      .op_reg     (opReg),
      .op_imm     (opImm),
      .arith_x    (arithX),
      .arith_v    (arithV),
      .arith_incr (arithIncr),
      .arith_decr (arithDecr),
      .arith_jizr (arithJizr),
      .arith_jnzr (arithJnzr),
      .arith_res  (arithRes),
      .pc         (pcOut),
      .rd_addr    (rdAddr),
      .rd_data    (rdData),
      .done       (doneOut),
      .taken      (takenOut)
   );

   // Clock generation, 10 time-unit period
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Arithmetic stage stub: incr/decr by one, jumps add 2*v or 16 when v is zero
   always_comb begin
      arithRes = 8'd0;
      if (arithIncr) begin
         arithRes = arithX + 8'd1;
      end else if (arithDecr) begin
         arithRes = arithX - 8'd1;
      end else if (arithJizr || arithJnzr) begin
         arithRes = (arithV == 3'd0) ? arithX + 8'd16 : arithX + {4'b0000, arithV, 1'b0};
      end
   end

   // Single comparison point: counts the vector and reports any miscompare
   task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
      nVec++;
      if (actual !== expected) begin
         nMis++;
         $display("[TB] FAIL %s at t=%0t: got 0x%02h, expected 0x%02h", name, $time, actual, expected);
      end
   endtask

   // Drive one cycle of inputs, then step past the next rising edge
   task automatic applyStimulus(input logic valid, input logic [1:0] code, input logic [2:0] r,
                                input logic [2:0] imm, input logic [2:0] rd, input logic rst);
      opValid = valid;
      opCode  = code;
      opReg   = r;
      opImm   = imm;
      rdAddr  = rd;
      reset   = rst;
      @(posedge clk);
      #1;
   endtask

   // Issue one op and idle through its exec and writeback cycles
   task automatic runOp(input logic [1:0] code, input logic [2:0] r, input logic [2:0] imm,
                        input logic [2:0] rd, output logic gotDone, output logic gotTaken);
      applyStimulus(1'b1, code, r, imm, rd, 1'b0);
      applyStimulus(1'b0, 2'd0, 3'd0, 3'd0, rd, 1'b0);
      gotDone  = doneOut;
      gotTaken = takenOut;
      applyStimulus(1'b0, 2'd0, 3'd0, 3'd0, rd, 1'b0);
   endtask

   task automatic doReset();
      applyStimulus(1'b0, 2'd0, 3'd0, 3'd0, 3'd0, 1'b1);
      applyStimulus(1'b0, 2'd0, 3'd0, 3'd0, 3'd0, 1'b0);
   endtask

   // Per-cycle compare against the model, then advance the model on the sampled inputs
   always @(negedge clk) begin
      if (checkEn) begin
         checkOutput("ready",   {7'd0, opReady}, {7'd0, mPhase == 0});
         checkOutput("done",    {7'd0, doneOut}, {7'd0, mPhase == 2});
         checkOutput("strobes", {4'd0, arithJnzr, arithJizr, arithDecr, arithIncr},
                     (mPhase == 1) ? (8'd1 << mOp) : 8'd0);
         checkOutput("pc",      pcOut, mPc);
         checkOutput("rdData",  rdData, mRegs[rdAddr]);
         if (mPhase == 1) begin
            checkOutput("arithX", arithX, mOp[1] ? mPc : mRegs[mReg]);
            checkOutput("arithV", {5'd0, arithV}, {5'd0, mImm});
         end
         if (mPhase == 2) begin
            checkOutput("taken", {7'd0, takenOut}, {7'd0, mTaken});
         end
      end
      if (reset) begin
         mPhase = 0;
         mRegs  = '{default: 8'd0};
         mPc    = 8'd0;
         mTaken = 1'b0;
      end else begin
         case (mPhase)
            0: begin
               if (opValid) begin
                  mOp    = opCode;
                  mReg   = opReg;
                  mImm   = opImm;
                  mPhase = 1;
               end
            end
            1: begin
               if (mOp == 2'd2) begin
                  mTaken = (mRegs[mReg] == 8'd0);
               end else if (mOp == 2'd3) begin
                  mTaken = (mRegs[mReg] != 8'd0);
               end else begin
                  mTaken = 1'b0;
               end
               mPhase = 2;
            end
            default: begin
               if (mOp == 2'd0) begin
                  mRegs[mReg] = mRegs[mReg] + 8'd1;
               end else if (mOp == 2'd1) begin
                  mRegs[mReg] = mRegs[mReg] - 8'd1;
               end
               if (mOp[1] && mTaken) begin
                  mPc = mPc + ((mImm == 3'd0) ? 8'd16 : {4'b0000, mImm, 1'b0});
               end else begin
                  mPc = mPc + 8'd1;
               end
               mPhase = 0;
            end
         endcase
      end
   end

   // Directed scenarios with hand-computed literal expectations
   initial begin
      opValid = 1'b0;
      opCode  = 2'd0;
      opReg   = 3'd0;
      opImm   = 3'd0;
      rdAddr  = 3'd0;
      reset   = 1'b1;
      applyStimulus(1'b0, 2'd0, 3'd0, 3'd0, 3'd0, 1'b1);
      applyStimulus(1'b0, 2'd0, 3'd0, 3'd0, 3'd0, 1'b1);
      checkEn = 1'b1;
      checkOutput("resetReady", {7'd0, opReady}, 8'd1);
      checkOutput("resetPc",    pcOut, 8'd0);
      checkOutput("resetDone",  {7'd0, doneOut}, 8'd0);
      applyStimulus(1'b0, 2'd0, 3'd0, 3'd0, 3'd0, 1'b0);

      // incr r3 three times
      for (int i = 0; i < 3; i++) begin
         runOp(2'd0, 3'd3, 3'd0, 3'd3, wbDone, wbTaken);
         checkOutput("s1Done", {7'd0, wbDone}, 8'd1);
      end
      checkOutput("s1R3", rdData, 8'd3);
      checkOutput("s1Pc", pcOut, 8'd3);

      // decr r5 from zero wraps, then incr wraps back
      runOp(2'd1, 3'd5, 3'd0, 3'd5, wbDone, wbTaken);
      checkOutput("s2Done",  {7'd0, wbDone}, 8'd1);
      checkOutput("s2Taken", {7'd0, wbTaken}, 8'd0);
      checkOutput("s2R5Dec", rdData, 8'hFF);
      runOp(2'd0, 3'd5, 3'd0, 3'd5, wbDone, wbTaken);
      checkOutput("s2R5Inc", rdData, 8'h00);
      checkOutput("s2Pc",    pcOut, 8'd5);

      // jumps on a zero register
      doReset();
      runOp(2'd2, 3'd2, 3'd0, 3'd2, wbDone, wbTaken);
      checkOutput("s3Pc10",   pcOut, 8'h10);
      runOp(2'd2, 3'd2, 3'd3, 3'd2, wbDone, wbTaken);
      checkOutput("s3JizrTk", {7'd0, wbTaken}, 8'd1);
      checkOutput("s3Pc16",   pcOut, 8'h16);
      runOp(2'd3, 3'd2, 3'd3, 3'd2, wbDone, wbTaken);
      checkOutput("s3JnzrTk", {7'd0, wbTaken}, 8'd0);
      checkOutput("s3Pc17",   pcOut, 8'h17);
      checkOutput("s3R2",     rdData, 8'd0);

      // default branch distance wrapping past 0xFF
      doReset();
      for (int i = 0; i < 7; i++) begin
         runOp(2'd0, 3'd1, 3'd0, 3'd1, wbDone, wbTaken);
      end
      for (int i = 0; i < 15; i++) begin
         runOp(2'd2, 3'd0, 3'd0, 3'd1, wbDone, wbTaken);
      end
      runOp(2'd3, 3'd0, 3'd0, 3'd1, wbDone, wbTaken);
      checkOutput("s4PcF8", pcOut, 8'hF8);
      runOp(2'd3, 3'd1, 3'd0, 3'd1, wbDone, wbTaken);
      checkOutput("s4Taken", {7'd0, wbTaken}, 8'd1);
      checkOutput("s4Pc08",  pcOut, 8'h08);
      checkOutput("s4R1",    rdData, 8'd7);

      // op_valid held high: only every third op is accepted
      doReset();
      for (int i = 0; i < 12; i++) begin
         applyStimulus(1'b1, 2'd0, (i % 2 == 0) ? 3'd6 : 3'd5, 3'd0, 3'd6, 1'b0);
      end
      checkOutput("s5R6", rdData, 8'd2);
      checkOutput("s5Pc", pcOut, 8'd4);
      applyStimulus(1'b0, 2'd0, 3'd0, 3'd0, 3'd5, 1'b0);
      checkOutput("s5R5", rdData, 8'd2);

      // reset during exec abandons the op
      doReset();
      runOp(2'd0, 3'd4, 3'd0, 3'd4, wbDone, wbTaken);
      checkOutput("s6R4Pre", rdData, 8'd1);
      applyStimulus(1'b1, 2'd0, 3'd4, 3'd0, 3'd4, 1'b0);
      applyStimulus(1'b0, 2'd0, 3'd0, 3'd0, 3'd4, 1'b1);
      checkOutput("s6Ready", {7'd0, opReady}, 8'd1);
      checkOutput("s6Pc",    pcOut, 8'd0);
      checkOutput("s6R4",    rdData, 8'd0);
      checkOutput("s6Done",  {7'd0, doneOut}, 8'd0);
      applyStimulus(1'b0, 2'd0, 3'd0, 3'd0, 3'd4, 1'b0);
      checkOutput("s6DoneLate", {7'd0, doneOut}, 8'd0);
      applyStimulus(1'b0, 2'd0, 3'd0, 3'd0, 3'd4, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
      $finish;
   end

endmodule
